// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of the register-file write port between ALU and load writeback
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   alu_valid/ready/rd/data      ALU result handshake into its FIFO
//   ld_valid/ready/rd/data       load-return handshake into its FIFO
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   idle                         both FIFOs empty and no write in flight
module wb_port_arbiter #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [REGW-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [REGW-1:0] ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [REGW-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // index 0 is the ALU source, index 1 the load source
    logic [1:0]          full, push, gnt;
    logic [1:0][AW-1:0]  wp, rp;
    logic [1:0][CW-1:0]  cnt;
    logic [REGW-1:0]     rd_m   [2][DEPTH];
    logic [XLEN-1:0]     data_m [2][DEPTH];
    logic                last_grant, sel;
    logic [REGW-1:0]     head_rd;
    logic [XLEN-1:0]     head_data;
    always_comb begin
        full[0]   = cnt[0] == CW'(DEPTH);
        full[1]   = cnt[1] == CW'(DEPTH);
        push      = {ld_valid, alu_valid} & ~full;
        // on a tie the load wins unless it was granted last
        gnt[1]    = cnt[1] != '0 && (cnt[0] == '0 || !last_grant);
        gnt[0]    = cnt[0] != '0 && !gnt[1];
        sel       = gnt[1];
        head_rd   = rd_m[sel][rp[sel]];
        head_data = data_m[sel][rp[sel]];
    end
    assign alu_ready = !full[0];
    assign ld_ready  = !full[1];
    assign idle      = cnt[0] == '0 && cnt[1] == '0 && !rf_we;
    always_ff @(posedge clk) begin
        if (push[0]) begin
            rd_m[0][wp[0]]   <= alu_rd;
            data_m[0][wp[0]] <= alu_data;
        end
        if (push[1]) begin
            rd_m[1][wp[1]]   <= ld_rd;
            data_m[1][wp[1]] <= ld_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            last_grant <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wp[s] <= wp[s] + AW'(1);
                if (gnt[s]) rp[s] <= rp[s] + AW'(1);
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(gnt[s]);
            end
            // writes to x0 are consumed silently but still shown on the address/data lines
            rf_we <= |gnt && head_rd != '0;
            if (|gnt) begin
                last_grant <= sel;
                rf_waddr   <= head_rd;
                rf_wdata   <= head_data;
            end
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback producers: the ALU result path and the data-memory load-return path.
- Each producer has a small per-source FIFO with a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle into a registered write-port interface.
- Sits between the EX/MEM result buses and the register file. It replaces the combinational LMD/ALUout writeback select once loads may return with variable latency.

Parameters:
XLEN, 32, data width of results and write port
REGW, 5, register index width
DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU FIFO can accept
alu_rd  input  REGW  ALU destination register
alu_data  input  XLEN  ALU result
ld_valid  input  1  load data offered
ld_ready  output  1  load FIFO can accept
ld_rd  input  REGW  load destination register
ld_data  input  XLEN  loaded data (already extended)
rf_we  output  1  register-file write enable
rf_waddr  output  REGW  register-file write address
rf_wdata  output  XLEN  register-file write data
idle  output  1  both FIFOs empty and no write in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Both FIFOs empty, so alu_ready=1, ld_ready=1, idle=1.
  - last_grant=ALU, so the first tie goes to LOAD.
- Reset mid-operation: all queued entries are discarded and no write occurs after the reset edge. Producers must re-offer.
- Handshake:
  - Transfer occurs on an edge where valid && ready. Data and rd are captured into that source's FIFO tail.
  - ready = !full, derived only from the FIFO count. A full FIFO is not ready even if it pops on the same edge; there is no pass-through.
  - valid may drop without a transfer. Once a transfer is offered, the data need not be held.
- FIFOs:
  - Each is DEPTH entries with a wrapping read/write pointer plus a count of width clog2(DEPTH)+1.
  - Push and pop on the same edge when not full leaves the count unchanged; pointers wrap modulo DEPTH.
  - Order within each source is strictly preserved.
- Arbitration is combinational from the FIFO heads each cycle:
  - Neither FIFO non-empty: no pop.
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source not equal to last_grant.
  - On a grant edge: pop the head, update last_grant, and register the output.
- Write port (registered):
  - On the edge after a grant, rf_we=1, with rf_waddr and rf_wdata taken from the popped entry.
  - If the popped rd==0, the entry is consumed, rf_we=0 and last_grant still updates. rf_waddr and rf_wdata still load the entry for debug.
  - With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
  - At most one write per cycle. Sustained throughput is one entry per cycle across both sources.
- Latency: an entry accepted on edge k into an empty FIFO with no competition is granted on edge k+1. rf_we is high for the cycle following edge k+1.
- Same rd from both sources: write order follows grant order. Hazard ordering is the responsibility of upstream control; this block does not detect conflicts.
- idle = (alu count==0) && (ld count==0) && !rf_we.
- No combinational path from alu_valid/ld_valid to alu_ready/ld_ready. No combinational path from any input to rf_*.

Test Plan:
- Reset, then a single ALU push (rd=5, data=0x0000_1234) -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 exactly one cycle after the grant edge; idle returns to 1 the next cycle.
- Simultaneous first pushes ALU(rd=1, 0xA) and LD(rd=2, 0xB) after reset -> LD write first, then ALU on the next cycle (tie goes to LOAD). A continued tie stream alternates LD, ALU, LD, ALU.
- Hold ld_valid=1 while the write port is saturated by the ALU with DEPTH=2 -> ld_ready drops after 2 accepts; all loads are later written in push order; no entry is lost or duplicated (scoreboard check).
- Push ALU rd=0 data=0xFFFF_FFFF -> entry consumed, rf_we stays 0, alu_ready restores, and last_grant flips (next tie grants LD).
- Fill both FIFOs, assert rst for one edge mid-drain -> rf_we=0 from the next cycle, both ready=1, idle=1, and no stale entry is written afterwards.
- Random valid/rd/data on both sources for 10k cycles -> every accepted rd!=0 entry is written exactly once, per-source order is preserved, and the gap between pending grants never exceeds 1 cycle.
